// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes/InvSubBytes engine: LANES bytes of the 128-bit state
// are substituted per cycle, with valid/ready handshakes on both sides.
module sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] stateIn,
  input  logic         inverse,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] stateOut,
  output logic         busy
);

  localparam int unsigned NGRP = 16 / LANES;
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Row-major FIPS-197 tables; entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // (255 - b) * 8 == {~b, 3'b000}
  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return SBOX_FWD[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return SBOX_INV[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [127:0]  work, work_next;
  logic          modeReg;
  logic [GW-1:0] grp;
  int unsigned   base;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inValid) state_next = BUSY;
      BUSY:    if (grp == LAST_GRP) state_next = DONE;
      DONE:    if (outReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each lane substitutes one byte of the selected group in place.
  always_comb begin
    work_next = work;
    base      = 32'(grp) * LANES;
    for (int unsigned j = 0; j < LANES; j++) begin
      work_next[(base + j) * 8 +: 8] = modeReg ? inv_sbox(work[(base + j) * 8 +: 8])
                                               : fwd_sbox(work[(base + j) * 8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work    <= '0;
      modeReg <= 1'b0;
      grp     <= '0;
    end else begin
      case (state)
        IDLE: if (inValid) begin
          work    <= stateIn;
          modeReg <= inverse;
          grp     <= '0;
        end
        BUSY: begin
          work <= work_next;
          grp  <= grp + GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);
  assign busy     = (state != IDLE);
  assign stateOut = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: one DUT per legal LANES value, each with
// its own driver and output monitor, checked against a computed S-box model.
module tb_sub_bytes_iter;

  localparam int unsigned NRAND = 1500;
  localparam logic [127:0] FIPS_IN  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
  localparam logic [127:0] FIPS_OUT = 128'hd4e0b81e27bfb44111985d52aef1e530;

  typedef struct {
    logic [127:0] d;
    int unsigned  c;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned gcyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference tables from the field inverse plus affine map.
  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] iv;
      logic [7:0] s;
      iv = '0;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
             ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  end

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
    localparam int unsigned L  = 1 << gi;
    localparam int unsigned NG = 16 / L;

    logic         reset = 1'b1;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [127:0] stateIn = '0;
    logic         inverse = 1'b0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [127:0] stateOut;
    logic         busy;
    bit           hold = 1'b0;
    bit           rnd = 1'b0;
    bit           fin = 1'b0;
    exp_t         sb [$];
    bit           pov = 1'b0;
    bit           phs = 1'b0;
    logic [127:0] pout = '0;

    sub_bytes_iter #(.LANES(L)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .inValid  (inValid),
      .inReady  (inReady),
      .stateIn  (stateIn),
      .inverse  (inverse),
      .outValid (outValid),
      .outReady (outReady),
      .stateOut (stateOut),
      .busy     (busy)
    );

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp);
      int unsigned n;
      exp_t e;
      n = 0;
      inValid = 1'b1;
      stateIn = d;
      inverse = inv;
      @(negedge clk);
      while (!inReady && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!inReady) check_eq($sformatf("L%0d_accept_timeout", L), 128'(inReady), 128'd1);
      else begin
        e.d = exp;
        e.c = gcyc;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      inValid = 1'b0;
      stateIn = rnd128();
      inverse = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out();
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      check_eq($sformatf("L%0d_drain", L), 128'(sb.size()), 128'd0);
    endtask

    initial begin
      outReady = 1'b1;
      forever begin
        @(posedge clk); #1;
        outReady = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    end

    always @(negedge clk) begin
      if (reset) begin
        sb.delete();
        pov = 1'b0;
        phs = 1'b0;
      end else begin
        if (phs) begin
          check_eq($sformatf("L%0d_post_hs_inReady", L), 128'(inReady), 128'd1);
          check_eq($sformatf("L%0d_post_hs_outValid", L), 128'(outValid), 128'd0);
        end else if (pov) begin
          check_eq($sformatf("L%0d_hold_outValid", L), 128'(outValid), 128'd1);
          check_eq($sformatf("L%0d_hold_stateOut", L), stateOut, pout);
        end
        if (outValid) begin
          check_eq($sformatf("L%0d_done_inReady", L), 128'(inReady), 128'd0);
          check_eq($sformatf("L%0d_done_busy", L), 128'(busy), 128'd1);
          if (!pov) begin
            check_eq($sformatf("L%0d_pending", L), 128'(sb.size()), 128'd1);
            if (sb.size() != 0)
              check_eq($sformatf("L%0d_latency", L), 128'(gcyc - sb[0].c), 128'(NG + 1));
          end
          if (outReady && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq($sformatf("L%0d_data", L), stateOut, e.d);
          end
        end
        pov  = outValid;
        pout = stateOut;
        phs  = outValid && outReady;
      end
    end

    initial begin
      int unsigned n;
      logic [127:0] d;
      logic inv;
      // inValid held during reset must not be accepted
      reset   = 1'b1;
      inValid = 1'b1;
      stateIn = rnd128();
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      inValid = 1'b0;
      @(negedge clk);
      check_eq($sformatf("L%0d_rst_inReady", L), 128'(inReady), 128'd1);
      check_eq($sformatf("L%0d_rst_outValid", L), 128'(outValid), 128'd0);
      check_eq($sformatf("L%0d_rst_busy", L), 128'(busy), 128'd0);
      check_eq($sformatf("L%0d_rst_stateOut", L), stateOut, 128'd0);
      @(posedge clk); #1;

      send(FIPS_IN, 1'b0, FIPS_OUT);       wait_out();
      send(FIPS_OUT, 1'b1, FIPS_IN);       wait_out();
      send('0, 1'b0, {16{8'h63}});         wait_out();
      send({16{8'hff}}, 1'b0, {16{8'h16}}); wait_out();
      send({16{8'h53}}, 1'b0, {16{8'hed}}); wait_out();
      send({16{8'hed}}, 1'b1, {16{8'h53}}); wait_out();

      // back-pressure with input noise while the result is held
      hold = 1'b1;
      d = rnd128();
      send(d, 1'b0, model(d, 1'b0));
      n = 0;
      while (!outValid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (10) begin
        inValid = 1'($urandom_range(0, 1));
        stateIn = rnd128();
        inverse = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      inValid = 1'b0;
      hold    = 1'b0;
      wait_out();

      // reset in the second cycle after the accept
      d = rnd128();
      send(d, 1'b1, model(d, 1'b1));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq($sformatf("L%0d_mid_rst_inReady", L), 128'(inReady), 128'd1);
      check_eq($sformatf("L%0d_mid_rst_outValid", L), 128'(outValid), 128'd0);
      check_eq($sformatf("L%0d_mid_rst_stateOut", L), stateOut, 128'd0);
      @(posedge clk); #1;
      d = rnd128();
      send(d, 1'b0, model(d, 1'b0));
      wait_out();

      rnd = 1'b1;
      for (int i = 0; i < NRAND; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        d   = rnd128();
        inv = 1'($urandom_range(0, 1));
        send(d, inv, model(d, inv));
      end
      wait_out();
      rnd = 1'b0;
      fin = 1'b1;
    end
  end

  initial begin
    int unsigned n;
    bit alldone;
    n = 0;
    alldone = 1'b0;
    while (!alldone && n < 90000) begin
      @(posedge clk);
      n++;
      alldone = g_lane[0].fin && g_lane[1].fin && g_lane[2].fin && g_lane[3].fin && g_lane[4].fin;
    end
    check_eq("all_lanes_done", 128'(alldone), 128'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
